// File: rtl/bpfcpu_fetch_arb.sv
// Round-robin instruction-fetch arbiter: one code-memory read port shared by N_CORES cores,
// with a per-core fetch-budget watchdog. Define BPFCPU_FETCH_STATS_EN to build the stall counter.
module bpfcpu_fetch_arb #(
  parameter int N_CORES         = 4,
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int INST_WIDTH      = 64,
  parameter int RD_LATENCY      = 1,
  parameter int BUDGET_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CORES-1:0]                 core_rd_en,
  input  logic [N_CORES*CODE_ADDR_WIDTH-1:0] core_rd_addr,
  output logic [N_CORES*INST_WIDTH-1:0]      core_inst_data,
  output logic [N_CORES-1:0]                 core_inst_valid,
  input  logic [N_CORES-1:0]                 core_start,
  input  logic [BUDGET_WIDTH-1:0]            budget,
  output logic [N_CORES-1:0]                 core_timeout,
  output logic                               mem_rd_en,
  output logic [CODE_ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic [INST_WIDTH-1:0]              mem_rd_data,
  output logic [31:0]                        stat_stall
);

  localparam int RR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int TAG_D = RD_LATENCY + 1;

  logic [RR_W-1:0]                        rr_q, rr_d;
  logic [N_CORES-1:0]                     inflight_q, inflight_d;
  logic [N_CORES-1:0]                     locked_q, locked_d;
  logic [N_CORES-1:0][BUDGET_WIDTH-1:0]   fcount_q, fcount_d;
  logic [TAG_D-1:0][N_CORES-1:0]          tag_q, tag_d;
  logic                                   mem_rd_en_q, mem_rd_en_d;
  logic [CODE_ADDR_WIDTH-1:0]             mem_rd_addr_q, mem_rd_addr_d;
  logic [N_CORES-1:0][INST_WIDTH-1:0]     data_q, data_d;
  logic [N_CORES-1:0]                     valid_q, valid_d;
  logic [N_CORES-1:0]                     timeout_q, timeout_d;

  logic [N_CORES-1:0] elig, over, req, grant, ret;
  logic               found;
  int                 win;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    elig          = '0;
    over          = '0;
    req           = '0;
    grant         = '0;
    found         = 1'b0;
    win           = 0;
    rr_d          = rr_q;
    mem_rd_addr_d = mem_rd_addr_q;
    data_d        = data_q;
    fcount_d      = fcount_q;
    ret           = tag_q[RD_LATENCY];

    // A start pulse re-arms the budget, so it also masks the over-budget test that cycle.
    for (int k = 0; k < N_CORES; k++) begin
      elig[k] = core_rd_en[k] && !inflight_q[k] && !locked_q[k];
      over[k] = (budget != '0) && (fcount_q[k] == budget) && !core_start[k];
      req[k]  = elig[k] && !over[k];
    end

    // Rotating priority: first scan rr..N-1, then wrap to 0..rr-1.
    for (int k = 0; k < N_CORES; k++) begin
      if (!found && req[k] && (k >= int'(rr_q))) begin
        found = 1'b1;
        win   = k;
      end
    end
    for (int k = 0; k < N_CORES; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        win   = k;
      end
    end

    for (int k = 0; k < N_CORES; k++) begin
      grant[k] = found && (win == k);
      if (grant[k]) mem_rd_addr_d = core_rd_addr[k*CODE_ADDR_WIDTH +: CODE_ADDR_WIDTH];
      if (ret[k])   data_d[k] = mem_rd_data;
      if (core_start[k])
        fcount_d[k] = grant[k] ? BUDGET_WIDTH'(1) : '0;
      else if (grant[k] && (fcount_q[k] != '1))
        fcount_d[k] = fcount_q[k] + BUDGET_WIDTH'(1);
    end
    if (found) rr_d = (win == N_CORES - 1) ? '0 : RR_W'(win + 1);

    mem_rd_en_d = found;
    tag_d[0]    = grant;
    for (int s = 1; s < TAG_D; s++) tag_d[s] = tag_q[s-1];
    inflight_d  = (inflight_q & ~ret) | grant;
    valid_d     = ret;
    timeout_d   = elig & over;
    locked_d    = (locked_q | timeout_d) & ~core_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= '0;
      inflight_q    <= '0;
      locked_q      <= '0;
      fcount_q      <= '0;
      tag_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      // NOTE: the per-core instruction registers are reset too, so no core sees pre-reset data.
      data_q        <= '0;
      valid_q       <= '0;
      timeout_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values.
      rr_q          <= rr_d;
      inflight_q    <= inflight_d;
      locked_q      <= locked_d;
      fcount_q      <= fcount_d;
      tag_q         <= tag_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign mem_rd_en       = mem_rd_en_q;
  assign mem_rd_addr     = mem_rd_addr_q;
  assign core_inst_data  = data_q;
  assign core_inst_valid = valid_q;
  assign core_timeout    = timeout_q;

`ifdef BPFCPU_FETCH_STATS_EN
  logic [31:0] stat_q, stat_d;
  logic [32:0] stat_sum;

  // Adds one per core that could have been granted but lost arbitration; saturates.
  always_comb begin
    stat_sum = {1'b0, stat_q};
    for (int k = 0; k < N_CORES; k++) begin
      if (req[k] && !grant[k]) stat_sum = stat_sum + 33'd1;
    end
    stat_d = stat_sum[32] ? '1 : stat_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_stall = stat_q;
`else
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_bpfcpu_fetch_arb.sv
// Testbench for bpfcpu_fetch_arb: directed scenarios plus a randomized run checked against
// a transaction-level model (round-robin pick, return queue, budget counters).
module tb_bpfcpu_fetch_arb;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int IW  = 64;
  localparam int LAT = 1;
  localparam int BW  = 16;
`ifdef BPFCPU_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int            core;
    int            due;
    logic [IW-1:0] data;
  } ret_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    core_rd_en;
  logic [N*AW-1:0] core_rd_addr;
  logic [N*IW-1:0] core_inst_data;
  logic [N-1:0]    core_inst_valid;
  logic [N-1:0]    core_start;
  logic [BW-1:0]   budget;
  logic [N-1:0]    core_timeout;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [IW-1:0]   mem_rd_data;
  logic [31:0]     stat_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] mem_arr  [1<<AW];
  logic [IW-1:0] mem_pipe [LAT];

  bpfcpu_fetch_arb #(
    .N_CORES(N), .CODE_ADDR_WIDTH(AW), .INST_WIDTH(IW), .RD_LATENCY(LAT), .BUDGET_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr),
    .core_inst_data(core_inst_data), .core_inst_valid(core_inst_valid),
    .core_start(core_start), .budget(budget), .core_timeout(core_timeout),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  // Synchronous code memory with LAT cycles of read latency.
  always @(posedge clk) begin
    mem_pipe[0] <= mem_rd_en ? mem_arr[mem_rd_addr] : '0;
    for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rd_data = mem_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    core_rd_en   = '0;
    core_rd_addr = '0;
    core_start   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({mem_rd_en, core_inst_valid, core_timeout} !== '0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0", {mem_rd_en, core_inst_valid, core_timeout});
    end
    n_checks++;
    if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_rd_addr); end
    n_checks++;
    if (core_inst_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", core_inst_data); end
    n_checks++;
    if (stat_stall !== 32'd0) begin n_fail++; $display("FAIL reset_stat: got %0d want 0", stat_stall); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle_en: got %b want 0", mem_rd_en); end
  endtask

  task automatic test_single();
    mem_arr[5]         = 64'hA5;
    core_rd_en[0]      = 1'b1;
    core_rd_addr[0+:AW] = AW'(5);
    tick();
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, core_inst_valid} !== {1'b1, AW'(5), 4'b0000}) begin
      n_fail++; $display("FAIL single_c1: got en=%b addr=%h v=%b want en=1 addr=005 v=0000", mem_rd_en, mem_rd_addr, core_inst_valid);
    end
    tick();
    n_checks++;
    if ({mem_rd_en, core_inst_valid} !== 5'b0) begin
      n_fail++; $display("FAIL single_c2: got en=%b v=%b want 0/0000", mem_rd_en, core_inst_valid);
    end
    tick();
    n_checks++;
    if (core_inst_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", core_inst_valid); end
    n_checks++;
    if (core_inst_data[0+:IW] !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", core_inst_data[0+:IW]); end
    core_rd_en[0] = 1'b0;
    tick();
    n_checks++;
    if ({mem_rd_en, core_inst_valid, core_inst_data[0+:IW]} !== {5'b0, 64'hA5}) begin
      n_fail++; $display("FAIL single_hold: got en=%b v=%b d=%h want 0/0000/a5", mem_rd_en, core_inst_valid, core_inst_data[0+:IW]);
    end
  endtask

  task automatic test_back_to_back();
    core_rd_en[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] a;
      a = AW'(16 + j);
      core_rd_addr[2*AW +: AW] = a;
      tick();
      n_checks++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, a}) begin
        n_fail++; $display("FAIL b2b_grant%0d: got en=%b addr=%h want en=1 addr=%h", j, mem_rd_en, mem_rd_addr, a);
      end
      repeat (2) tick();
      n_checks++;
      if ({core_inst_valid, core_inst_data[2*IW +: IW]} !== {4'b0100, mem_arr[a]}) begin
        n_fail++; $display("FAIL b2b_ret%0d: got v=%b d=%h want v=0100 d=%h", j, core_inst_valid, core_inst_data[2*IW +: IW], mem_arr[a]);
      end
    end
    core_rd_en[2] = 1'b0;
    tick();
  endtask

  task automatic watch_core1(input int cycles, output int grants, output int tos,
                             output int last_val, output int to_edge);
    grants = 0; tos = 0; last_val = -1; to_edge = -1;
    for (int c = 1; c <= cycles; c++) begin
      tick();
      core_start = '0;
      if (mem_rd_en) grants++;
      if (core_inst_valid[1]) last_val = c;
      if (core_timeout[1]) begin tos++; to_edge = c; end
    end
  endtask

  task automatic test_watchdog();
    int grants, tos, last_val, to_edge;
    budget = 16'd3;
    core_start[1] = 1'b1;
    tick();
    core_start[1] = 1'b0;
    core_rd_en[1] = 1'b1;
    core_rd_addr[1*AW +: AW] = AW'(32);
    watch_core1(24, grants, tos, last_val, to_edge);
    n_checks++;
    if (grants !== 3) begin n_fail++; $display("FAIL wd_grants: got %0d want 3", grants); end
    n_checks++;
    if (tos !== 1) begin n_fail++; $display("FAIL wd_timeouts: got %0d want 1", tos); end
    n_checks++;
    if (last_val !== 3*(LAT+2)) begin n_fail++; $display("FAIL wd_last_valid: got %0d want %0d", last_val, 3*(LAT+2)); end
    n_checks++;
    if (to_edge !== 3*(LAT+2)+1) begin n_fail++; $display("FAIL wd_timeout_edge: got %0d want %0d", to_edge, 3*(LAT+2)+1); end
    // Restart with the request still held: unlock edge, then three more grants and a timeout.
    core_start[1] = 1'b1;
    watch_core1(24, grants, tos, last_val, to_edge);
    n_checks++;
    if (grants !== 3) begin n_fail++; $display("FAIL wd_resume_grants: got %0d want 3", grants); end
    n_checks++;
    if (to_edge !== 3*(LAT+2)+2) begin n_fail++; $display("FAIL wd_resume_timeout: got edge %0d want %0d", to_edge, 3*(LAT+2)+2); end
    core_rd_en[1] = 1'b0;
    budget        = '0;
    core_start[1] = 1'b1;
    tick();
    core_start[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int seen;
    core_rd_en[3] = 1'b1;
    core_rd_addr[3*AW +: AW] = AW'(48);
    tick();
    n_checks++;
    if ({mem_rd_en, mem_rd_addr} !== {1'b1, AW'(48)}) begin
      n_fail++; $display("FAIL rmr_grant: got en=%b addr=%h want en=1 addr=030", mem_rd_en, mem_rd_addr);
    end
    tick();
    rst_n      = 1'b0;
    core_rd_en = '0;
    #1;
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, core_inst_valid, core_timeout, core_inst_data} !== '0) begin
      n_fail++; $display("FAIL rmr_async_clear: got en=%b addr=%h v=%b want all 0", mem_rd_en, mem_rd_addr, core_inst_valid);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 0;
    repeat (5) begin
      tick();
      if ({mem_rd_en, mem_rd_addr, core_inst_valid, core_timeout, core_inst_data, stat_stall} !== '0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rmr_after_release: got %0d nonzero cycles want 0", seen); end
  endtask

  task automatic test_stats();
    core_rd_addr[0+:AW]  = AW'(100);
    core_rd_addr[AW+:AW] = AW'(101);
    core_rd_en = 4'b0011;
    tick();
    n_checks++;
    if ({mem_rd_en, mem_rd_addr} !== {1'b1, AW'(100)}) begin
      n_fail++; $display("FAIL stats_first_grant: got en=%b addr=%h want en=1 addr=064", mem_rd_en, mem_rd_addr);
    end
    n_checks++;
    if (stat_stall !== 32'(STATS)) begin n_fail++; $display("FAIL stats_one: got %0d want %0d", stat_stall, STATS); end
    tick();
    core_rd_en = '0;
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, stat_stall} !== {1'b1, AW'(101), 32'(STATS)}) begin
      n_fail++; $display("FAIL stats_second: got en=%b addr=%h stat=%0d want 1/065/%0d", mem_rd_en, mem_rd_addr, stat_stall, STATS);
    end
    repeat (3) tick();
  endtask

  task automatic test_all_cores();
    do_reset();
    for (int k = 0; k < N; k++) core_rd_addr[k*AW +: AW] = AW'(64*k + k);
    core_rd_en = '1;
    for (int i = 1; i <= 12; i++) begin
      int c;
      c = (i - 1) % N;
      tick();
      n_checks++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, AW'(64*c + c)}) begin
        n_fail++; $display("FAIL all_grant%0d: got en=%b addr=%h want en=1 addr=%h", i, mem_rd_en, mem_rd_addr, AW'(64*c + c));
      end
      if (i >= LAT + 2) begin
        n_checks++;
        if (core_inst_valid !== N'(1 << ((i - LAT - 2) % N))) begin
          n_fail++; $display("FAIL all_valid%0d: got %b want %b", i, core_inst_valid, N'(1 << ((i - LAT - 2) % N)));
        end
      end
    end
    core_rd_en = '0;
    repeat (4) tick();
  endtask

  task automatic test_random(input int cycles);
    int            pending[N], fcount[N];
    bit            locked[N], need_start[N], cand[N], ovr[N];
    logic [IW-1:0] exp_data[N];
    ret_t          rq[$];
    int            last, e, win;
    longint        exp_stat;
    logic [N-1:0]  exp_to, exp_val;
    logic [AW-1:0] exp_addr;
    bit            exp_en;

    budget = 16'd5;
    do_reset();
    for (int k = 0; k < N; k++) begin
      pending[k] = 0; fcount[k] = 0; locked[k] = 0; need_start[k] = 0; exp_data[k] = '0;
    end
    last = N - 1; e = 0; exp_stat = 0; exp_addr = '0;

    for (int c = 0; c < cycles; c++) begin
      // Core agents: react to last cycle's outputs.
      core_start = '0;
      if (c % 400 == 399) budget = BW'($urandom_range(6));
      for (int k = 0; k < N; k++) begin
        if (core_rd_en[k]) begin
          if (core_timeout[k]) begin
            core_rd_en[k] = 1'b0; need_start[k] = 1'b1;
          end else if (core_inst_valid[k]) begin
            if ($urandom_range(2) != 0) core_rd_addr[k*AW +: AW] = AW'($urandom);
            else core_rd_en[k] = 1'b0;
          end
        end else if ($urandom_range(3) == 0) begin
          if (need_start[k] || $urandom_range(7) == 0) begin
            core_start[k] = 1'b1; need_start[k] = 1'b0;
          end else begin
            core_rd_en[k] = 1'b1; core_rd_addr[k*AW +: AW] = AW'($urandom);
          end
        end
      end

      // Reference model: what the next edge must produce.
      exp_to = '0; exp_val = '0; win = -1;
      for (int k = 0; k < N; k++) begin
        cand[k] = core_rd_en[k] && (pending[k] == 0) && !locked[k];
        ovr[k]  = (budget != '0) && (fcount[k] == int'(budget));
        if (cand[k] && ovr[k]) exp_to[k] = 1'b1;
      end
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (last + i) % N;
        if (win < 0 && cand[k] && !ovr[k]) win = k;
      end
      e++;
      while (rq.size() > 0 && rq[0].due == e) begin
        exp_val[rq[0].core]  = 1'b1;
        exp_data[rq[0].core] = rq[0].data;
        pending[rq[0].core]  = 0;
        void'(rq.pop_front());
      end
      exp_en = (win >= 0);
      if (exp_en) begin
        exp_addr = core_rd_addr[win*AW +: AW];
        last = win;
        pending[win] = 1;
        rq.push_back('{win, e + LAT + 1, mem_arr[exp_addr]});
      end
      for (int k = 0; k < N; k++) begin
        if (STATS && cand[k] && !ovr[k] && k != win) exp_stat++;
        if (core_start[k]) fcount[k] = (k == win) ? 1 : 0;
        else if (k == win && fcount[k] < (1 << BW) - 1) fcount[k]++;
        if (core_start[k]) locked[k] = 1'b0;
        else if (exp_to[k]) locked[k] = 1'b1;
      end

      tick();

      n_checks++;
      if (mem_rd_en !== exp_en) begin n_fail++; $display("FAIL rnd_en@%0d: got %b want %b", e, mem_rd_en, exp_en); end
      if (exp_en) begin
        n_checks++;
        if (mem_rd_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", e, mem_rd_addr, exp_addr); end
      end
      n_checks++;
      if (core_inst_valid !== exp_val) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", e, core_inst_valid, exp_val); end
      n_checks++;
      if (core_timeout !== exp_to) begin n_fail++; $display("FAIL rnd_timeout@%0d: got %b want %b", e, core_timeout, exp_to); end
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (core_inst_data[k*IW +: IW] !== exp_data[k]) begin
          n_fail++; $display("FAIL rnd_data%0d@%0d: got %h want %h", k, e, core_inst_data[k*IW +: IW], exp_data[k]);
        end
      end
      n_checks++;
      if (stat_stall !== 32'(exp_stat)) begin n_fail++; $display("FAIL rnd_stat@%0d: got %0d want %0d", e, stat_stall, exp_stat); end
    end
    core_rd_en = '0;
    budget     = '0;
    repeat (4) tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    core_rd_en   = '0;
    core_rd_addr = '0;
    core_start   = '0;
    budget       = '0;
    foreach (mem_arr[i]) mem_arr[i] = {$urandom, $urandom};
    test_reset();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_read();
    test_stats();
    test_all_cores();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
